// File: rtl/ntt_pkg.sv
// Shared types and constants for the single-butterfly NTT datapath and its scheduler.
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Operand-in to E/O-out latency of the butterfly (CT and GS are equal) per modulus width.
  localparam int BU_LAT_Q32 = 8;
  localparam int BU_LAT_Q64 = 10;
  localparam int RD_LAT_DEF = 1;

  function automatic int drain_depth(input int rd_lat, input int lat);
    return rd_lat + lat;
  endfunction

  function automatic int stage_width(input int logn);
    return $clog2(logn) + 1;
  endfunction

endpackage

// File: rtl/bu_addr_gen.sv
// Combinational coefficient-pair and twiddle address map for one butterfly (s,k),
// CT (forward, decreasing stride) or GS (inverse, increasing stride) ordering.
module bu_addr_gen
  import ntt_pkg::*;
#(
  parameter int LOGN = 8
) (
  input  logic [stage_width(LOGN)-1:0] s,
  input  logic [LOGN-2:0]              k,
  input  logic                         ct,
  output logic [LOGN-1:0]              addr_a,
  output logic [LOGN-1:0]              addr_b,
  output logic [LOGN-1:0]              tw_addr
);

  localparam int SW = stage_width(LOGN);
  localparam logic [LOGN:0] N_C      = {1'b1, {LOGN{1'b0}}};
  localparam logic [LOGN:0] ONE_C    = {{LOGN{1'b0}}, 1'b1};
  localparam logic [SW-1:0] S_ONE_C  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] S_LOGN_C = SW'(LOGN);

  logic [LOGN:0]   k_s;
  logic [LOGN:0]   t_s;
  logic [LOGN:0]   j_s;
  logic [LOGN-1:0] a_s;
  logic [LOGN-1:0] b_s;
  logic [LOGN-1:0] tw_s;

  assign k_s = {2'b00, k};

  // Stride t, group j and twiddle base m; addr_a = j*2t + (k mod t) built from shifts only.
  always_comb begin
    if (ct) begin
      t_s  = N_C >> (s + S_ONE_C);
      j_s  = k_s >> (S_LOGN_C - S_ONE_C - s);
      a_s  = LOGN'((j_s << (S_LOGN_C - s)) | (k_s & (t_s - ONE_C)));
      tw_s = LOGN'((ONE_C << s) + j_s);
    end else begin
      t_s  = ONE_C << s;
      j_s  = k_s >> s;
      a_s  = LOGN'((j_s << (s + S_ONE_C)) | (k_s & (t_s - ONE_C)));
      tw_s = LOGN'((N_C >> (s + S_ONE_C)) + j_s);
    end
    b_s = LOGN'({1'b0, a_s} + t_s);
  end

  assign addr_a  = a_s;
  assign addr_b  = b_s;
  assign tw_addr = tw_s;

endmodule

// File: rtl/ntt_bu_sched.sv
// Butterfly scheduler: walks all NTT stages issuing one butterfly per cycle, drains the
// datapath between stages, and replays issue addresses as write-backs after RD_LAT+LAT.
module ntt_bu_sched
  import ntt_pkg::*;
#(
  parameter int LOGN   = 8,
  parameter int LAT    = BU_LAT_Q32,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode_ct,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_addr,
  output logic            bu_ct,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam int D  = drain_depth(RD_LAT, LAT);
  localparam int SW = stage_width(LOGN);
  localparam int CW = $clog2(D + 1);

  localparam logic [LOGN-2:0] K_LAST_C = {(LOGN-1){1'b1}};
  localparam logic [LOGN-2:0] K_ONE_C  = {{(LOGN-2){1'b0}}, 1'b1};
  localparam logic [SW-1:0]   S_LAST_C = SW'(LOGN - 1);
  localparam logic [SW-1:0]   S_ONE_C  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   D_C      = CW'(D);
  localparam logic [CW-1:0]   C_ONE_C  = {{(CW-1){1'b0}}, 1'b1};

  state_e          state_r, state_s;
  logic [SW-1:0]   stage_r, stage_s;
  logic [LOGN-2:0] bfly_r, bfly_s;
  logic [CW-1:0]   drain_r, drain_s;
  logic            ct_r, ct_s;

  logic [LOGN-1:0] gen_a_s, gen_b_s, gen_tw_s;

  logic            busy_r, done_r, rd_en_r, bu_ct_r;
  logic [LOGN-1:0] rd_addr_a_r, rd_addr_b_r, tw_addr_r;

  logic [D-1:0]           dl_vld_r;
  logic [D-1:0][LOGN-1:0] dl_a_r, dl_b_r;

  bu_addr_gen #(.LOGN(LOGN)) u_addr_gen (
    .s       (stage_s),
    .k       (bfly_s),
    .ct      (ct_s),
    .addr_a  (gen_a_s),
    .addr_b  (gen_b_s),
    .tw_addr (gen_tw_s)
  );

  // Next state, stage/butterfly counters and drain countdown.
  always_comb begin
    state_s = state_r;
    stage_s = stage_r;
    bfly_s  = bfly_r;
    drain_s = drain_r;
    ct_s    = ct_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          ct_s    = mode_ct;
          stage_s = {SW{1'b0}};
          bfly_s  = {(LOGN-1){1'b0}};
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (bfly_r == K_LAST_C) begin
          state_s = DRAIN;
          drain_s = D_C;
        end else begin
          bfly_s = bfly_r + K_ONE_C;
        end
      end
      DRAIN: begin
        // Leaving on count 1 puts the stage's last write-back in this final drain cycle.
        if (drain_r == C_ONE_C) begin
          if (stage_r == S_LAST_C) begin
            state_s = DONE;
          end else begin
            stage_s = stage_r + S_ONE_C;
            bfly_s  = {(LOGN-1){1'b0}};
            state_s = ISSUE;
          end
        end else begin
          drain_s = drain_r - C_ONE_C;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      stage_r <= {SW{1'b0}};
      bfly_r  <= {(LOGN-1){1'b0}};
      drain_r <= {CW{1'b0}};
      ct_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      stage_r <= stage_s;
      bfly_r  <= bfly_s;
      drain_r <= drain_s;
      ct_r    <= ct_s;
    end
  end

  // Registered issue-side outputs, computed from the next state so they align with rd_en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      bu_ct_r     <= 1'b0;
      rd_addr_a_r <= {LOGN{1'b0}};
      rd_addr_b_r <= {LOGN{1'b0}};
      tw_addr_r   <= {LOGN{1'b0}};
    end else begin
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      rd_en_r <= (state_s == ISSUE);
      bu_ct_r <= ct_s;
      if (state_s == ISSUE) begin
        rd_addr_a_r <= gen_a_s;
        rd_addr_b_r <= gen_b_s;
        tw_addr_r   <= gen_tw_s;
      end
    end
  end

  // Write-back delay line; clearing it on reset drops butterflies still in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dl_vld_r <= {D{1'b0}};
      dl_a_r   <= {(D*LOGN){1'b0}};
      dl_b_r   <= {(D*LOGN){1'b0}};
    end else begin
      dl_vld_r <= {dl_vld_r[D-2:0], rd_en_r};
      dl_a_r   <= {dl_a_r[D-2:0], rd_addr_a_r};
      dl_b_r   <= {dl_b_r[D-2:0], rd_addr_b_r};
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign rd_en     = rd_en_r;
  assign rd_addr_a = rd_addr_a_r;
  assign rd_addr_b = rd_addr_b_r;
  assign tw_addr   = tw_addr_r;
  assign bu_ct     = bu_ct_r;
  assign wr_en     = dl_vld_r[D-1];
  assign wr_addr_a = dl_a_r[D-1];
  assign wr_addr_b = dl_b_r[D-1];

endmodule
